// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator (LSL, LSR, ASR, ROL) with valid/ready flow control.
// Define SHIFTER_CARRY_EN to carry the last shifted-out bit to OUT_CARRY; FORMAL enables the property checks.
module pipe_shifter #(
  parameter int WIDTH   = 32,
  parameter int MID_REG = 1
) (
  input  logic                     CLK,
  input  logic                     N_RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH-1:0]         IN,
  input  logic [$clog2(WIDTH)-1:0] SHFT,
  input  logic [1:0]               OP,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT,
  output logic                     OUT_CARRY
);

  localparam int SW = $clog2(WIDTH);
  localparam int H  = (SW + 1) / 2;
  localparam int HB = SW - H;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    return {<<{d}};
  endfunction

  // Left shift by k; vacated low bits take the wrapped-out bits (rotate) or the fill bit.
  function automatic logic [WIDTH-1:0] shl_stage(input logic [WIDTH-1:0] d, input int k,
                                                 input logic fill, input logic rot);
    logic [WIDTH-1:0] low;
    low = rot ? (d >> (WIDTH - k)) : ({WIDTH{fill}} & ~({WIDTH{1'b1}} << k));
    return (d << k) | low;
  endfunction

`ifdef SHIFTER_CARRY_EN
  // Last bit leaving the top of d when shifted left by k.
  function automatic logic out_bit(input logic [WIDTH-1:0] d, input int k);
    logic [WIDTH-1:0] t;
    t = d >> (WIDTH - k);
    return t[0];
  endfunction
`endif

  logic             vld_p0;
  logic [WIDTH-1:0] dat_p0;
  logic [SW-1:0]    shft_p0;
  logic [1:0]       op_p0;
  logic             adv_p0;

  logic             vld_p2;
  logic [WIDTH-1:0] dat_p2;
  logic             ld_p2;

  logic [WIDTH-1:0] fr_dat;
  logic             fr_fill;
  logic             fr_rot;
  logic             fr_rev;

  logic             m_vld;
  logic [WIDTH-1:0] m_dat;
  logic [HB-1:0]    m_shft;
  logic             m_fill;
  logic             m_rot;
  logic             m_rev;

  logic [WIDTH-1:0] bk_dat;
  logic [WIDTH-1:0] res;

`ifdef SHIFTER_CARRY_EN
  logic             fr_cry;
  logic             m_cry;
  logic             bk_cry;
  logic             cry_p2;
`endif

  assign IN_READY = !vld_p0 || adv_p0;
  assign ld_p2    = !vld_p2 || OUT_READY;

  // ---- stage p0: input register, loaded only on handshake ----
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      vld_p0  <= 1'b0;
      dat_p0  <= '0;
      shft_p0 <= '0;
      op_p0   <= '0;
    end else if (IN_READY) begin
      vld_p0 <= IN_VALID;
      if (IN_VALID) begin
        dat_p0  <= IN;
        shft_p0 <= SHFT;
        op_p0   <= OP;
      end
    end
  end

  // Right shifts run as left shifts on the bit-reversed operand; rotate is never reversed.
  always_comb begin
    logic [SW-1:0] s;
    fr_rev  = op_p0[1] ^ op_p0[0];
    fr_rot  = &op_p0;
    fr_fill = (op_p0 == 2'b10) & dat_p0[WIDTH-1];
    fr_dat  = fr_rev ? bit_rev(dat_p0) : dat_p0;
`ifdef SHIFTER_CARRY_EN
    fr_cry  = 1'b0;
`endif
    s = shft_p0;
    for (int j = 0; j < H; j++) begin
      if (s[0]) begin
`ifdef SHIFTER_CARRY_EN
        fr_cry = out_bit(fr_dat, 1 << j);
`endif
        fr_dat = shl_stage(fr_dat, 1 << j, fr_fill, fr_rot);
      end
      s = s >> 1;
    end
  end

  // ---- stage p1: optional mid-pipeline register after the low half of the mux stages ----
  generate
    if (MID_REG != 0) begin : g_mid
      logic             vld_p1;
      logic [WIDTH-1:0] dat_p1;
      logic [HB-1:0]    shft_p1;
      logic             fill_p1;
      logic             rot_p1;
      logic             rev_p1;
      logic             ld_p1;
`ifdef SHIFTER_CARRY_EN
      logic             cry_p1;
`endif

      assign ld_p1  = !vld_p1 || ld_p2;
      assign adv_p0 = ld_p1;

      always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
          vld_p1  <= 1'b0;
          dat_p1  <= '0;
          shft_p1 <= '0;
          fill_p1 <= 1'b0;
          rot_p1  <= 1'b0;
          rev_p1  <= 1'b0;
`ifdef SHIFTER_CARRY_EN
          cry_p1  <= 1'b0;
`endif
        end else if (ld_p1) begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            dat_p1  <= fr_dat;
            shft_p1 <= shft_p0[SW-1:H];
            fill_p1 <= fr_fill;
            rot_p1  <= fr_rot;
            rev_p1  <= fr_rev;
`ifdef SHIFTER_CARRY_EN
            cry_p1  <= fr_cry;
`endif
          end
        end
      end

      assign m_vld  = vld_p1;
      assign m_dat  = dat_p1;
      assign m_shft = shft_p1;
      assign m_fill = fill_p1;
      assign m_rot  = rot_p1;
      assign m_rev  = rev_p1;
`ifdef SHIFTER_CARRY_EN
      assign m_cry  = cry_p1;
`endif
    end else begin : g_nomid
      assign adv_p0 = ld_p2;
      assign m_vld  = vld_p0;
      assign m_dat  = fr_dat;
      assign m_shft = shft_p0[SW-1:H];
      assign m_fill = fr_fill;
      assign m_rot  = fr_rot;
      assign m_rev  = fr_rev;
`ifdef SHIFTER_CARRY_EN
      assign m_cry  = fr_cry;
`endif
    end
  endgenerate

  always_comb begin
    logic [HB-1:0] s;
    bk_dat = m_dat;
`ifdef SHIFTER_CARRY_EN
    bk_cry = m_cry;
`endif
    s = m_shft;
    for (int j = H; j < SW; j++) begin
      if (s[0]) begin
`ifdef SHIFTER_CARRY_EN
        bk_cry = out_bit(bk_dat, 1 << j);
`endif
        bk_dat = shl_stage(bk_dat, 1 << j, m_fill, m_rot);
      end
      s = s >> 1;
    end
    res = m_rev ? bit_rev(bk_dat) : bk_dat;
  end

  // ---- stage p2: output register, held while the consumer stalls ----
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      vld_p2 <= 1'b0;
      dat_p2 <= '0;
`ifdef SHIFTER_CARRY_EN
      cry_p2 <= 1'b0;
`endif
    end else if (ld_p2) begin
      vld_p2 <= m_vld;
      if (m_vld) begin
        dat_p2 <= res;
`ifdef SHIFTER_CARRY_EN
        cry_p2 <= bk_cry;
`endif
      end
    end
  end

  assign OUT_VALID = vld_p2;
  assign OUT       = dat_p2;
`ifdef SHIFTER_CARRY_EN
  assign OUT_CARRY = cry_p2;
`else
  assign OUT_CARRY = 1'b0;
`endif

`ifdef FORMAL
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SW-1:0] s, input logic [1:0] op);
    int si;
    si = int'(s);
    case (op)
      2'b00:   return d << si;
      2'b01:   return d >> si;
      2'b10:   return $signed(d) >>> si;
      default: return (si == 0) ? d : ((d << si) | (d >> (WIDTH - si)));
    endcase
  endfunction

  logic [WIDTH-1:0] ref_p1;
  logic [WIDTH-1:0] ref_p2;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      ref_p1 <= '0;
      ref_p2 <= '0;
    end else begin
      if (adv_p0 && vld_p0) ref_p1 <= ref_shift(dat_p0, shft_p0, op_p0);
      if (ld_p2 && m_vld)
        ref_p2 <= (MID_REG != 0) ? ref_p1 : ref_shift(dat_p0, shft_p0, op_p0);
    end
  end

  a_equiv: assert property (@(posedge CLK) disable iff (!N_RST) OUT_VALID |-> (OUT == ref_p2));
  a_stall: assert property (@(posedge CLK) disable iff (!N_RST)
                            (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(OUT) && $stable(OUT_CARRY)));
`endif

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: fixed vectors, random back-to-back stream, output stall and mid-flight reset.
module tb_pipe_shifter;
  localparam int WIDTH   = 32;
  localparam int MID_REG = 1;
  localparam int LAT     = (MID_REG != 0) ? 3 : 2;
`ifdef SHIFTER_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [4:0]  sh;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        out_carry;

  pipe_shifter #(.WIDTH(WIDTH), .MID_REG(MID_REG)) dut (
    .CLK(clk), .N_RST(n_rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN(din), .SHFT(sh), .OP(op), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT(dout), .OUT_CARRY(out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  sh;
    logic [31:0] eout;
    logic        ecry;
  } vec_t;

  typedef struct {
    logic [31:0] eout;
    logic        ecry;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  vec_t        tab[12];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          feed = 0;
  bit          chk_lat = 0;
  bit          use_tab = 0;
  bit          fired = 0;
  bit          stall_prev = 0;
  logic [31:0] tab_out;
  logic        tab_cry;
  logic [31:0] held_out;
  logic        held_cry;

  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    logic [31:0] r;
    logic [31:0] t;
    logic        c;
    int          si;
    si = int'(s);
    case (o)
      2'b00:   r = d << si;
      2'b01:   r = d >> si;
      2'b10:   r = $signed(d) >>> si;
      default: r = (si == 0) ? d : ((d << si) | (d >> (32 - si)));
    endcase
    if (si == 0) c = 1'b0;
    else if (o == 2'b00) begin t = d >> (32 - si); c = t[0]; end
    else if (o == 2'b11) c = r[0];
    else begin t = d >> (si - 1); c = t[0]; end
    return {c & CARRY_EN, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic rand_in();
    op = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0:       din = 32'h8000_0000 | $urandom_range(0, 255);
      1:       din = 32'hFFFF_FFFF;
      2:       din = 32'h0000_0001;
      default: din = $urandom;
    endcase
    case ($urandom_range(0, 3))
      0:       sh = 5'd0;
      1:       sh = 5'd31;
      default: sh = 5'($urandom_range(0, 31));
    endcase
  endtask

  // One clock: sample handshakes just after the falling edge, score, then move to the next falling edge.
  task automatic tick();
    exp_t        e;
    logic [32:0] m;
    #1;
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_out", 64'(dout), 64'(held_out));
      check("stall_carry", 64'(out_carry), 64'(held_cry));
    end
    stall_prev = out_valid && !out_ready;
    held_out   = dout;
    held_cry   = out_carry;
    fired      = in_valid && in_ready;
    if (fired) begin
      if (use_tab) begin
        e.eout = tab_out;
        e.ecry = tab_cry & CARRY_EN;
      end else begin
        m = model(din, sh, op);
        e.eout = m[31:0];
        e.ecry = m[32];
      end
      e.acc = cyc;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %08h with no pending op, required none (cycle %0d)", dout, cyc);
      end else begin
        e = sb.pop_front();
        check("out", 64'(dout), 64'(e.eout));
        check("carry", 64'(out_carry), 64'(e.ecry));
        if (chk_lat) check("latency", 64'(cyc - e.acc), 64'(LAT));
      end
    end
    @(negedge clk);
    cyc++;
    if (feed && fired) rand_in();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t;
    tab[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    tab[1]  = '{2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
    tab[2]  = '{2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0};
    tab[3]  = '{2'b01, 32'h8000_00F0, 5'd4,  32'h0800_000F, 1'b0};
    tab[4]  = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b1};
    tab[5]  = '{2'b00, 32'hC000_0000, 5'd1,  32'h8000_0000, 1'b1};
    tab[6]  = '{2'b01, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b1};
    tab[7]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
    tab[8]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    tab[9]  = '{2'b11, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b1};
    tab[10] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1};
    tab[11] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1};

    n_rst = 1'b0; in_valid = 1'b0; din = '0; sh = '0; op = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(dout), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Fixed vectors, one at a time
    use_tab = 1; chk_lat = 1;
    foreach (tab[i]) begin
      op = tab[i].op; din = tab[i].din; sh = tab[i].sh;
      tab_out = tab[i].eout; tab_cry = tab[i].ecry;
      in_valid = 1'b1;
      tick();
      check("vec_accept", 64'(fired), 64'd1);
      in_valid = 1'b0;
      drain();
    end

    // 100 random ops back to back at full throughput
    use_tab = 0; feed = 1; chk_lat = 1;
    rand_in();
    in_valid = 1'b1;
    n = 0; t = 0;
    while (n < 100 && t < 200) begin
      tick();
      if (fired) n++;
      t++;
    end
    check("throughput_cycles", 64'(t), 64'd100);
    feed = 0; in_valid = 1'b0;
    drain();

    // Stream into a stalled consumer, hold, then release
    chk_lat = 0; feed = 1; out_ready = 1'b0;
    rand_in();
    in_valid = 1'b1;
    n = 0;
    repeat (LAT + 5) begin
      tick();
      if (fired) n++;
    end
    check("stall_accepts", 64'(n), 64'(LAT));
    check("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    repeat (10) tick();
    feed = 0; in_valid = 1'b0;
    drain();

    // Reset with ops in flight
    chk_lat = 1; feed = 1;
    rand_in();
    in_valid = 1'b1;
    repeat (3) tick();
    feed = 0; in_valid = 1'b0;
    check("inflight_valid", 64'(out_valid), 64'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(dout), 64'd0);
    check("midrst_carry", 64'(out_carry), 64'd0);
    sb.delete();
    stall_prev = 0;
    @(negedge clk);
    cyc++;
    n_rst = 1'b1;
    repeat (5) tick();
    use_tab = 1;
    op = 2'b11; din = 32'h8000_0001; sh = 5'd1;
    tab_out = 32'h0000_0003; tab_cry = 1'b1;
    in_valid = 1'b1;
    tick();
    check("post_rst_accept", 64'(fired), 64'd1);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
